// File: rtl/instr_buffer_pkg.sv
// Shared types and defaults for the instruction buffer slice.
// FETCH_PACKET is the per-lane record passed from fetch to dispatch.
package instr_buffer_pkg;

    localparam int IB_SZ_DEF       = 16;
    localparam int IB_IDX_BITS_DEF = $clog2(IB_SZ_DEF);

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        is_branch;
        logic        bp_pred_taken;
        logic [31:0] bp_pred_target;
        logic [7:0]  bp_ghr_snapshot;
    } FETCH_PACKET;

endpackage

// File: rtl/instr_buffer_compact.sv
// ib_compact: packs the valid lanes of a 4-lane fetch packet into the low
// slots in ascending lane order and reports how many lanes were valid.
// Shared by the array write path and the (optional) dispatch bypass path.
module ib_compact
    import instr_buffer_pkg::*;
(
    input  FETCH_PACKET [3:0] lanes_i,
    output FETCH_PACKET [3:0] packed_o,
    output logic [2:0]        push_n_o
);

    // Prefix-popcount compaction: each valid lane lands at the number of valid lanes below it
    always_comb begin
        logic [2:0] n;
        packed_o = '0;
        n        = '0;
        for (int i = 0; i < 4; i++) begin
            if (lanes_i[i].valid) begin
                packed_o[n[1:0]] = lanes_i[i];
                n = n + 3'd1;
            end
        end
        push_n_o = n;
    end

endmodule

// File: rtl/instr_buffer.sv
// instr_buffer: circular instruction buffer between fetch and dispatch.
// Compacts sparse fetch lanes onto the tail, presents the oldest entries to
// dispatch, reports free slots to fetch and empties in one cycle on flush.
// Optional feature macro IB_BYPASS_EN: same-cycle bypass of incoming lanes to
// dispatch while the buffer holds fewer than DISPATCH_WIDTH entries.
module instr_buffer
    import instr_buffer_pkg::*;
#(
    parameter int IB_SZ          = IB_SZ_DEF,
    parameter int DISPATCH_WIDTH = 2
)
(
    input  logic                                  clock,
    input  logic                                  reset,
    input  FETCH_PACKET [3:0]                     fetch_packet,
    input  logic                                  flush,
    output logic [$clog2(IB_SZ):0]                ib_free_slots,
    output FETCH_PACKET [DISPATCH_WIDTH-1:0]      dispatch_packet,
    input  logic [$clog2(DISPATCH_WIDTH+1)-1:0]   dispatch_take,
    output logic                                  overflow_err
);

    localparam int IDX_W = $clog2(IB_SZ);

    FETCH_PACKET [3:0]  packed_lanes;
    logic [2:0]         push_n;

    FETCH_PACKET        mem_q [IB_SZ];
    FETCH_PACKET        mem_d [IB_SZ];
    logic [IDX_W-1:0]   head_q, head_d;
    logic [IDX_W-1:0]   tail_q, tail_d;
    logic [IDX_W:0]     count_q, count_d;
    logic               ovf_q, ovf_d;

    int                 cnt_i, avail_st, pres_i, take_i, pop_i;
    int                 pop_st, byp_i, space_i, wr_i;
    logic               ovf_hit;

    ib_compact u_compact (
        .lanes_i  (fetch_packet),
        .packed_o (packed_lanes),
        .push_n_o (push_n)
    );

    // Occupancy bookkeeping: how many entries are presented, popped, bypassed and written
    always_comb begin
        cnt_i    = int'(count_q);
        avail_st = (cnt_i < DISPATCH_WIDTH) ? cnt_i : DISPATCH_WIDTH;
        pres_i   = avail_st;
`ifdef IB_BYPASS_EN
        if (!flush) begin
            pres_i = avail_st + int'(push_n);
            if (pres_i > DISPATCH_WIDTH) pres_i = DISPATCH_WIDTH;
        end
`endif
        take_i  = int'(dispatch_take);
        pop_i   = (take_i < pres_i) ? take_i : pres_i;
        // Stored entries are always older than bypassed ones, so they are consumed first
        pop_st  = (pop_i < avail_st) ? pop_i : avail_st;
        byp_i   = pop_i - pop_st;
        // Slots vacated by this cycle's pop are reusable by this cycle's push
        space_i = IB_SZ - cnt_i + pop_st;
        wr_i    = int'(push_n) - byp_i;
        ovf_hit = 1'b0;
        if (wr_i > space_i) begin
            ovf_hit = 1'b1;
            wr_i    = space_i;
        end
    end

    // Dispatch presentation: stored entries from head, then optional bypass lanes
    always_comb begin
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            dispatch_packet[i] = '0;
            if (i < avail_st) begin
                dispatch_packet[i]       = mem_q[head_q + IDX_W'(i)];
                dispatch_packet[i].valid = 1'b1;
            end
`ifdef IB_BYPASS_EN
            else if (!flush && (i - avail_st) < int'(push_n)) begin
                dispatch_packet[i] = packed_lanes[2'(i - avail_st)];
            end
`endif
        end
    end

    // Next-state: pointers, count, sticky overflow and array writes; flush discards everything
    always_comb begin
        mem_d  = mem_q;
        head_d = head_q + IDX_W'(pop_st);
        tail_d = tail_q + IDX_W'(wr_i);
        count_d = count_q + (IDX_W+1)'(wr_i) - (IDX_W+1)'(pop_st);
        ovf_d  = ovf_q | ovf_hit;
        for (int k = 0; k < 4; k++) begin
            if (k < wr_i) begin
                mem_d[tail_q + IDX_W'(k)] = packed_lanes[2'(k + byp_i)];
            end
        end
        if (flush) begin
            mem_d   = mem_q;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            ovf_d   = ovf_q;
        end
    end

    // Control state is reset; array contents are don't-care after reset
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Entry array update
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign ib_free_slots = (IDX_W+1)'(IB_SZ) - count_q;
    assign overflow_err  = ovf_q;

endmodule
